// File: rtl/ofm_reader_pkg.sv
// Shared CNN feature-map definitions: memory depth, byte-lane geometry,
// reader FSM states and the word-to-lanes unpacking helper.
package ofm_reader_pkg;

  localparam int unsigned OFM_DEPTH = 128;
  localparam int unsigned LANES     = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef logic [LANES-1:0][BYTE_W-1:0] lanes_t;

  // Lane 0 carries the most significant byte, matching the OFM writer packing.
  function automatic lanes_t unpack_word(input logic [LANES*BYTE_W-1:0] w);
    lanes_t r;
    for (int unsigned l = 0; l < LANES; l++) begin
      r[l] = w[(LANES-1-l)*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofm_reader_skid_fifo2.sv
// Two-entry shift FIFO of byte-lane words. Entry 0 is always the head, so the
// head stays stable while the consumer stalls.
module skid_fifo2
  import ofm_reader_pkg::*;
#(
  parameter int unsigned LANES_P = LANES,
  parameter int unsigned BW_P    = BYTE_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [LANES_P-1:0][BW_P-1:0]  data_i,
  output logic [LANES_P-1:0][BW_P-1:0]  head_o,
  output logic                          full_o,
  output logic                          empty_o
);

  logic [1:0]                   cnt_q;
  logic [LANES_P-1:0][BW_P-1:0] e0_q;
  logic [LANES_P-1:0][BW_P-1:0] e1_q;
  logic                         do_pop;
  logic                         do_push;
  logic                         wr_hi;

  // Qualify requests; a push lands in entry 1 when entry 0 stays occupied.
  always_comb begin
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    wr_hi   = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !do_pop);
  end

  // Shift on pop, then write the incoming word behind whatever remains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      if (do_pop) e0_q <= e1_q;
      if (do_push) begin
        if (wr_hi) e1_q <= data_i;
        else       e0_q <= data_i;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = e0_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ofm_reader.sv
// Feature-map burst reader: issues word reads from a 1-cycle-latency memory,
// unpacks each word into byte lanes and hands them to a valid/ready consumer
// through a 2-entry buffer.
module ofm_reader
  import ofm_reader_pkg::*;
#(
  parameter int unsigned DEPTH = OFM_DEPTH,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    word_count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [31:0]   mem_data,
  output logic [7:0]    rdData [3:0],
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [8:0]    remain_q;
  logic          inflight_q;
  logic          busy_q;
  logic          done_q;

  logic [8:0]    wc_ext;
  logic [8:0]    wc_sat;
  logic [AW-1:0] addr_d;
  lanes_t        mem_lanes;
  lanes_t        fifo_head;
  lanes_t        out_lanes;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          valid_w;
  logic          will_empty;
  logic          issue;

  // Returning data bypasses the empty buffer so the first word is valid in
  // the cycle mem_data arrives; it is only stored if the consumer stalls.
  always_comb begin
    wc_ext     = {1'b0, word_count};
    wc_sat     = (wc_ext > 9'(DEPTH)) ? 9'(DEPTH) : wc_ext;
    addr_d     = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    mem_lanes  = unpack_word(mem_data);
    valid_w    = !fifo_empty || inflight_q;
    fifo_pop   = valid_w && rd_ready && !fifo_empty;
    fifo_push  = inflight_q && !(fifo_empty && rd_ready);
    will_empty = (fifo_empty && !fifo_push) ||
                 (!fifo_empty && !fifo_full && fifo_pop && !fifo_push);
    issue      = (state_q == S_FETCH) && (remain_q != '0) && !fifo_full &&
                 !(inflight_q && !fifo_empty);
    out_lanes  = !fifo_empty ? fifo_head : (inflight_q ? mem_lanes : '0);
  end

  // Present the head word as individual byte lanes.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      rdData[l] = out_lanes[l];
    end
  end

  // Burst control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q   <= base_addr % AW'(DEPTH);
            remain_q <= wc_sat;
            if (wc_sat != '0) begin
              state_q <= S_FETCH;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            addr_q   <= addr_d;
            remain_q <= remain_q - 1'b1;
            if (remain_q == 9'd1) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (will_empty) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  skid_fifo2 #(
    .LANES_P(LANES),
    .BW_P   (BYTE_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .data_i (mem_lanes),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign mem_addr = addr_q;
  assign mem_rd   = issue;
  assign rd_valid = valid_w;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ofm_reader.sv
// Self-checking bench for ofm_reader: a queue-based model of the burst
// (expected addresses and words, outstanding-word count, busy/done timing)
// checked every cycle, plus literal expectations for directed bursts.
module tb_ofm_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  word_count;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic [7:0]  rdData [3:0];
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ofm_reader #(.DEPTH(128), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rdData    (rdData),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .done      (done)
  );

  logic [31:0] mem [128];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr % 128];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct { int cyc; logic [31:0] val; } ev_t;
  ev_t         xlog[$];
  ev_t         alog[$];
  int          exp_addr[$];
  logic [31:0] exp_word[$];
  bit          armed = 0, m_busy = 0, m_done = 0, prev_stall = 0, last, nd;
  int          outst = 0, max_out = 0, cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, n;
  logic [31:0] w, prev_word;
  int          rmode = 0;
  logic        rforce = 1'b1;

  // Per-cycle compare against the behavioural model, then advance the model.
  always @(negedge clk) begin
    cyc++;
    w    = {rdData[0], rdData[1], rdData[2], rdData[3]};
    last = 0;
    if (armed) begin
      chk("done", done, m_done);
      chk("busy", busy, m_busy);
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (!m_busy) chk("rd_valid_idle", rd_valid, 0);
      if (prev_stall) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_data", w, prev_word);
      end
      if (mem_rd) begin
        chk("rd_room", {31'b0, outst < 2}, 1);
        if (exp_addr.size() == 0) chk("rd_unexpected", mem_rd, 0);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
        alog.push_back('{cyc: cyc, val: mem_addr});
        outst++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_word.size() == 0) chk("xfer_unexpected", rd_valid & rd_ready, 0);
        else begin
          chk("rdData", w, exp_word.pop_front());
          last = (exp_word.size() == 0);
        end
        xlog.push_back('{cyc: cyc, val: w});
        outst--;
      end
      if (outst > max_out) max_out = outst;
    end
    prev_stall = armed && rd_valid && !rd_ready && !rst;
    prev_word  = w;
    if (rst) begin
      armed = 1; m_busy = 0; m_done = 0; outst = 0; prev_stall = 0;
      exp_addr.delete(); exp_word.delete();
    end else if (armed) begin
      nd = 0;
      if (m_busy && last) begin
        m_busy = 0; nd = 1;
      end else if (!m_busy && !m_done && start) begin
        n = (word_count > 8'd128) ? 128 : int'(word_count);
        start_cyc = cyc;
        if (n == 0) nd = 1;
        else begin
          m_busy = 1;
          for (int i = 0; i < n; i++) begin
            exp_addr.push_back(int'((base_addr + 32'(i)) % 128));
            exp_word.push_back(mem[(base_addr + 32'(i)) % 128]);
          end
        end
      end
      m_done = nd;
    end
  end

  // Consumer ready: always, random, or scripted.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #3;
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = rforce;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  task automatic pulse_start(input logic [31:0] b, input logic [7:0] c);
    @(posedge clk); #2;
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  task automatic clear_logs();
    xlog.delete(); alog.delete();
  endtask

  int          exp_a[4];
  logic [31:0] exp_w[4];

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; mem_data = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA0B0C0D0 + 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdData", {rdData[0], rdData[1], rdData[2], rdData[3]}, 0);

    // Start in the very first cycle after reset release.
    clear_logs();
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b1; base_addr = 0; word_count = 4;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("done_b0", 50);
    chk("b0_count", xlog.size(), 4);
    if (xlog.size() == 4 && alog.size() == 4) begin
      chk("b0_first", xlog[0].val, 32'hA0B0C0D0);
      chk("b0_last", xlog[3].val, 32'hA0B0C0D3);
      chk("b0_consecutive", xlog[3].cyc - xlog[0].cyc, 3);
      chk("b0_done_lat", done_cyc, xlog[3].cyc + 1);
      chk("b0_rd_lat", alog[0].cyc, start_cyc + 1);
      chk("b0_valid_lat", xlog[0].cyc, alog[0].cyc + 1);
    end

    // Address wrap.
    clear_logs();
    exp_a = '{126, 127, 0, 1};
    exp_w = '{32'hA0B0C14E, 32'hA0B0C14F, 32'hA0B0C0D0, 32'hA0B0C0D1};
    pulse_start(126, 4);
    wait_done("done_wrap", 50);
    chk("wrap_count", xlog.size(), 4);
    if (xlog.size() == 4 && alog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("wrap_addr", alog[i].val, exp_a[i]);
        chk("wrap_word", xlog[i].val, exp_w[i]);
      end

    // Zero-length burst.
    clear_logs();
    pulse_start(7, 0);
    wait_done("done_zero", 5);
    chk("zero_no_rd", alog.size(), 0);
    chk("zero_lat", {31'b0, (done_cyc - start_cyc) <= 2}, 1);

    // Consumer stall of 5 cycles mid-burst.
    clear_logs();
    rmode = 2; rforce = 1'b1; max_out = 0;
    pulse_start(20, 8);
    @(posedge clk); #2; rforce = 1'b0;
    repeat (5) @(posedge clk);
    #2; rforce = 1'b1;
    wait_done("done_stall", 100);
    chk("stall_count", xlog.size(), 8);
    chk("stall_max_buf", max_out, 2);
    if (xlog.size() == 8) chk("stall_last", xlog[7].val, 32'hA0B0C0EB);
    rmode = 0;

    // Start while busy is ignored.
    clear_logs();
    pulse_start(40, 6);
    @(posedge clk); #2;
    start = 1'b1; base_addr = 0; word_count = 3;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("done_busy_start", 60);
    chk("busy_start_count", xlog.size(), 6);
    if (xlog.size() == 6 && alog.size() == 6) begin
      chk("busy_start_a0", alog[0].val, 40);
      chk("busy_start_last", xlog[5].val, 32'hA0B0C0FD);
    end

    // Oversized count saturates to the memory depth.
    clear_logs();
    rmode = 1;
    pulse_start(5, 200);
    wait_done("done_sat", 1500);
    chk("sat_count", xlog.size(), 128);
    if (xlog.size() == 128 && alog.size() == 128) begin
      chk("sat_last_addr", alog[127].val, 4);
      chk("sat_last_word", xlog[127].val, 32'hA0B0C0D4);
    end
    rmode = 0;

    // Reset mid-burst aborts without a done pulse.
    clear_logs();
    done_cnt = 0;
    pulse_start(50, 8);
    for (int i = 0; i < 20 && xlog.size() < 2; i++) begin
      @(posedge clk); #2;
    end
    chk("rst_burst_pre", {31'b0, xlog.size() >= 2}, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_rd", mem_rd, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    clear_logs();
    pulse_start(10, 2);
    wait_done("done_after_abort", 20);
    chk("post_abort_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("post_abort_w0", xlog[0].val, 32'hA0B0C0DA);
      chk("post_abort_w1", xlog[1].val, 32'hA0B0C0DB);
    end

    // Randomized bursts against the model.
    for (int k = 0; k < 25; k++) begin
      rmode = ($urandom_range(0, 2) == 0) ? 0 : 1;
      pulse_start($urandom_range(0, 1000),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 12)));
      wait_done("done_rand", 1500);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
